// File: rtl/fetch_buffer.sv
// fetch_buffer
// ------------
// Fetch stage between the PC register and decode. Requests instructions from
// instruction memory (grant/valid handshake, at most one request in flight),
// queues returned words with their PCs in a DEPTH-entry FIFO and presents the
// head to decode over valid/ready. Drives the PC register update enable and
// handles redirect flushes, dropping any response that belongs to a request
// issued before the flush.
//
// Parameters:
//   WIDTH - PC / address width in bits
//   DEPTH - FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset (0 = reset)
//   fetch_pc     current PC from the PC register
//   pc_en        PC register load enable (granted fetch or redirect)
//   flush        redirect from execute; empties the FIFO
//   imem_req     fetch request valid
//   imem_addr    fetch address (= fetch_pc)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   instruction word
//   id_valid     FIFO head valid towards decode
//   id_ready     decode accepts the head
//   id_instr     head instruction (0 while empty)
//   id_pc        PC of the head instruction (0 while empty)
//   id_pc_plus4  id_pc + 4, wrapping
//   id_misalign  head entry came from a misaligned PC
//                (only with FETCH_MISALIGN_CHECK_EN defined)
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a misaligned
// fetch_pc does not reach memory; a NOP tagged as misaligned is queued instead
// and fetching stops until the next flush.

module fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pc_en,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [WIDTH-1:0] id_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic             id_misalign
`else
  output logic [WIDTH-1:0] id_pc_plus4
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // State
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             outstanding_q, outstanding_d;
  logic             discard_q, discard_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;

  // FIFO storage
  logic [31:0]      instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  // Control
  logic [CW:0]      occ;
  logic             issue_ok;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  logic [31:0]      wr_instr;
  logic [WIDTH-1:0] wr_pc;

  // Reserve a slot for the in-flight request so a response never overflows.
  assign occ = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic stopped_q, stopped_d;
  logic misaligned;
  logic mis_push;
  logic misalign_mem [DEPTH];

  assign misaligned = |fetch_pc[1:0];
  assign issue_ok   = rst & ~flush & (~outstanding_q | imem_rvalid)
                    & (occ < DEPTH_W) & ~stopped_q;
  assign imem_req   = issue_ok & ~misaligned;
  // The NOP is queued only when no response can land in the same cycle, so
  // the FIFO takes at most one write per edge. If a response is arriving, the
  // NOP is simply queued one cycle later.
  assign mis_push   = issue_ok & misaligned & ~outstanding_q;
`else
  assign issue_ok   = rst & ~flush & (~outstanding_q | imem_rvalid)
                    & (occ < DEPTH_W);
  assign imem_req   = issue_ok;
`endif

  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign pc_en     = grant | flush;

  // Responses only count while a request is in flight.
  assign resp      = imem_rvalid & outstanding_q;
  assign id_valid  = (count_q != '0);
  assign pop       = id_valid & id_ready & ~flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign push      = (resp & ~discard_q & ~flush) | mis_push;
  assign wr_instr  = mis_push ? 32'h0000_0013 : imem_rdata;
  assign wr_pc     = mis_push ? fetch_pc : req_pc_q;
`else
  assign push      = resp & ~discard_q & ~flush;
  assign wr_instr  = imem_rdata;
  assign wr_pc     = req_pc_q;
`endif

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    req_pc_d      = req_pc_q;

    if (grant) begin
      req_pc_d      = fetch_pc;
      outstanding_d = 1'b1;
    end else if (resp) begin
      outstanding_d = 1'b0;
    end

    if (flush) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      // A request still in flight after the flush must have its data dropped.
      // If the response lands in the flush cycle it is consumed right here.
      discard_d = outstanding_q & ~imem_rvalid;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (resp && discard_q) discard_d = 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    stopped_d = stopped_q;
    if (flush)         stopped_d = 1'b0;
    else if (mis_push) stopped_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stopped_q <= 1'b0;
    else      stopped_q <= stopped_d;
  end

  always_ff @(posedge clk) begin
    if (push) misalign_mem[wr_ptr_q] <= mis_push;
  end

  assign id_misalign = id_valid & misalign_mem[rd_ptr_q];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      req_pc_q      <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      req_pc_q      <= req_pc_d;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= wr_instr;
      pc_mem[wr_ptr_q]    <= wr_pc;
    end
  end

  // Head is read asynchronously so it is visible the cycle it becomes valid.
  assign id_instr    = id_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign id_pc       = id_valid ? pc_mem[rd_ptr_q] : '0;
  assign id_pc_plus4 = id_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
// Directed bench for fetch_buffer. The main process drives stimulus and pushes
// the hand-computed expected decode-side entries into a scoreboard queue; a
// monitor pops and compares on every accepted decode transfer. A small memory
// model answers granted requests with rdata = addr ^ 32'hC0DE_0000, and a PC
// model reloads fetch_pc on pc_en (redirect target on flush, else +4).

module tb_fetch_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misalign;
`endif

  logic        mem_rvalid;
  logic        spur;
  logic [31:0] redirect;
  int          mem_lat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign imem_rvalid = mem_rvalid | spur;

  fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .id_pc_plus4 (id_pc_plus4),
    .id_misalign (id_misalign)
`else
    .id_pc_plus4 (id_pc_plus4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic exp_push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pcp4);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pcp4  = pcp4;
    sb.push_back(e);
  endtask

  // Monitor: one comparison set per accepted decode transfer.
  always @(negedge clk) begin
    if (rst && id_valid && id_ready && !flush) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc 0x%08h expected no transfer", id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("pop pc=0x%08h instr=0x%08h pc4=0x%08h", id_pc, id_instr, id_pc_plus4);
        chk("pop_instr", id_instr, e.instr);
        chk("pop_pc", id_pc, e.pc);
        chk("pop_pc_plus4", id_pc_plus4, e.pcp4);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("pop_misalign", {31'b0, id_misalign}, 32'h0);
`endif
      end
    end
  end

  // Memory model: response mem_lat cycles after the granting edge.
  initial begin : mem_model
    logic        g_s;
    logic [31:0] a_s;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    mem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    pend       = 1'b0;
    pend_cnt   = 0;
    pend_addr  = 32'h0;
    forever begin
      @(negedge clk);
      g_s = imem_req & imem_gnt;
      a_s = imem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          imem_rdata = pend_addr ^ KEY;
          pend       = 1'b0;
        end
      end
      if (g_s) begin
        if (mem_lat <= 1) begin
          mem_rvalid = 1'b1;
          imem_rdata = a_s ^ KEY;
        end else begin
          pend      = 1'b1;
          pend_cnt  = mem_lat - 1;
          pend_addr = a_s;
        end
      end
    end
  end

  // PC register model.
  initial begin : pc_model
    logic        s_rst, s_en, s_fl;
    logic [31:0] s_tgt;
    fetch_pc = 32'h0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_en  = pc_en;
      s_fl  = flush;
      s_tgt = redirect;
      @(posedge clk);
      #1;
      if (!s_rst)    fetch_pc = 32'h0;
      else if (s_en) fetch_pc = s_fl ? s_tgt : fetch_pc + 32'd4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int grants;
    logic [31:0] wrap_addr [6];
    wrap_addr = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8,
                  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    rst      = 1'b0;
    imem_gnt = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    spur     = 1'b0;
    redirect = 32'h0;
    mem_lat  = 1;

    // Reset, two cycles with grant asserted
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
      chk("rst_pc_en", {31'b0, pc_en}, 32'h0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
      tick();
    end

    // Streaming: three grants 0x0, 0x4, 0x8 with decode always ready
    exp_push(32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004);
    exp_push(32'hC0DE_0004, 32'h0000_0004, 32'h0000_0008);
    exp_push(32'hC0DE_0008, 32'h0000_0008, 32'h0000_000C);
    rst      = 1'b1;
    id_ready = 1'b1;
    neg();
    chk("stream_req0", {31'b0, imem_req}, 32'h1);
    chk("stream_addr0", imem_addr, 32'h0000_0000);
    chk("stream_pc_en0", {31'b0, pc_en}, 32'h1);
    tick();
    neg();
    chk("stream_addr1", imem_addr, 32'h0000_0004);
    chk("stream_pc_en1", {31'b0, pc_en}, 32'h1);
    tick();
    neg();
    chk("stream_addr2", imem_addr, 32'h0000_0008);
    chk("stream_pc_en2", {31'b0, pc_en}, 32'h1);
    tick();
    imem_gnt = 1'b0;
    neg();
    chk("stream_hold_pc_en", {31'b0, pc_en}, 32'h0);
    chk("stream_hold_pc", fetch_pc, 32'h0000_000C);
    for (int i = 0; i < 3; i++) tick();
    neg();
    chk("stream_drained", 32'(sb.size()), 32'h0);
    chk("stream_empty", {31'b0, id_valid}, 32'h0);

    // Backpressure: redirect to 0, decode stalled, expect exactly DEPTH grants
    tick();
    flush    = 1'b1;
    redirect = 32'h0;
    neg();
    chk("flush_pc_en", {31'b0, pc_en}, 32'h1);
    chk("flush_no_req", {31'b0, imem_req}, 32'h0);
    exp_push(32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004);
    exp_push(32'hC0DE_0004, 32'h0000_0004, 32'h0000_0008);
    exp_push(32'hC0DE_0008, 32'h0000_0008, 32'h0000_000C);
    exp_push(32'hC0DE_000C, 32'h0000_000C, 32'h0000_0010);
    exp_push(32'hC0DE_0010, 32'h0000_0010, 32'h0000_0014);
    tick();
    flush    = 1'b0;
    imem_gnt = 1'b1;
    id_ready = 1'b0;
    neg();
    grants = 0;
    for (int i = 0; i < 7; i++) begin
      if (pc_en) grants++;
      tick();
      neg();
    end
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_full_req", {31'b0, imem_req}, 32'h0);
    chk("bp_full_pc_en", {31'b0, pc_en}, 32'h0);
    chk("bp_pc_held", fetch_pc, 32'h0000_0010);
    chk("bp_valid", {31'b0, id_valid}, 32'h1);
    tick();
    id_ready = 1'b1;
    neg();
    chk("bp_pop_no_credit", {31'b0, imem_req}, 32'h0);
    tick();
    id_ready = 1'b0;
    neg();
    chk("bp_refill_req", {31'b0, imem_req}, 32'h1);
    chk("bp_refill_addr", imem_addr, 32'h0000_0010);
    chk("bp_refill_pc_en", {31'b0, pc_en}, 32'h1);
    tick();
    imem_gnt = 1'b0;
    neg();
    chk("bp_single_req", {31'b0, pc_en}, 32'h0);
    tick();
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    neg();
    chk("bp_drained", 32'(sb.size()), 32'h0);

    // Flush while a request is outstanding; stale data must be dropped
    tick();
    flush    = 1'b1;
    redirect = 32'h0000_0020;
    neg();
    tick();
    flush    = 1'b0;
    mem_lat  = 3;
    imem_gnt = 1'b1;
    neg();
    chk("fl_grant_addr", imem_addr, 32'h0000_0020);
    chk("fl_grant_pc_en", {31'b0, pc_en}, 32'h1);
    tick();
    flush    = 1'b1;
    redirect = 32'h0000_0100;
    neg();
    chk("fl_flush_no_req", {31'b0, imem_req}, 32'h0);
    chk("fl_flush_pc_en", {31'b0, pc_en}, 32'h1);
    exp_push(32'hC0DE_0100, 32'h0000_0100, 32'h0000_0104);
    tick();
    flush   = 1'b0;
    mem_lat = 1;
    neg();
    chk("fl_wait_no_req", {31'b0, imem_req}, 32'h0);
    chk("fl_new_pc", fetch_pc, 32'h0000_0100);
    chk("fl_empty", {31'b0, id_valid}, 32'h0);
    tick();
    neg();
    chk("fl_refetch_req", {31'b0, imem_req}, 32'h1);
    chk("fl_refetch_addr", imem_addr, 32'h0000_0100);
    tick();
    imem_gnt = 1'b0;
    neg();
    chk("fl_stale_dropped", {31'b0, id_valid}, 32'h0);
    tick();
    neg();
    chk("fl_new_valid", {31'b0, id_valid}, 32'h1);
    tick();
    neg();
    chk("fl_drained", 32'(sb.size()), 32'h0);

    // Wrap: PC crosses 2^32 and FIFO pointers wrap after 6 push/pop pairs
    tick();
    flush    = 1'b1;
    redirect = 32'hFFFF_FFF0;
    neg();
    exp_push(32'h3F21_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF4);
    exp_push(32'h3F21_FFF4, 32'hFFFF_FFF4, 32'hFFFF_FFF8);
    exp_push(32'h3F21_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    exp_push(32'h3F21_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    exp_push(32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004);
    exp_push(32'hC0DE_0004, 32'h0000_0004, 32'h0000_0008);
    tick();
    flush    = 1'b0;
    imem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      neg();
      chk("wrap_addr", imem_addr, wrap_addr[i]);
      chk("wrap_pc_en", {31'b0, pc_en}, 32'h1);
      tick();
    end
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    neg();
    chk("wrap_drained", 32'(sb.size()), 32'h0);

    // Spurious rvalid with nothing outstanding is ignored
    tick();
    spur = 1'b1;
    neg();
    tick();
    spur = 1'b0;
    neg();
    chk("spur_ignored", {31'b0, id_valid}, 32'h0);

    // Misaligned PC
    tick();
    flush    = 1'b1;
    redirect = 32'h0000_0102;
    neg();
    tick();
    flush    = 1'b0;
    id_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    imem_gnt = 1'b1;
    neg();
    chk("mis_no_req", {31'b0, imem_req}, 32'h0);
    chk("mis_no_pc_en", {31'b0, pc_en}, 32'h0);
    tick();
    neg();
    chk("mis_valid", {31'b0, id_valid}, 32'h1);
    chk("mis_instr", id_instr, 32'h0000_0013);
    chk("mis_pc", id_pc, 32'h0000_0102);
    chk("mis_flag", {31'b0, id_misalign}, 32'h1);
    chk("mis_stop_req", {31'b0, imem_req}, 32'h0);
    tick();
    neg();
    chk("mis_stop_pc_en", {31'b0, pc_en}, 32'h0);
    chk("mis_stop_pc", fetch_pc, 32'h0000_0102);
    tick();
    flush    = 1'b1;
    redirect = 32'h0;
    neg();
    tick();
    flush    = 1'b0;
    imem_gnt = 1'b0;
    neg();
    chk("mis_flushed", {31'b0, id_valid}, 32'h0);
`else
    neg();
    chk("align_pass_req", {31'b0, imem_req}, 32'h1);
    chk("align_pass_addr", imem_addr, 32'h0000_0102);
`endif

    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Fetch stage directly downstream of the PC block.
- Takes the current program counter, issues instruction-memory requests over a grant/valid handshake, and queues returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents the queued instructions to decode over a valid/ready handshake.
- Drives the PC register's update enable and handles branch/jump redirect flushes.

Parameters:
- WIDTH, 32, address/PC width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- fetch_pc  in  WIDTH  current PC from the PC register
- pc_en  out  1  PC register update enable (load next PC at the edge)
- flush  in  1  redirect: PCsrc taken in execute
- imem_req  out  1  fetch request valid
- imem_addr  out  WIDTH  fetch address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- id_valid  out  1  decode-side instruction valid
- id_ready  in  1  decode accepts
- id_instr  out  32  instruction at the FIFO head
- id_pc  out  WIDTH  PC of id_instr
- id_pc_plus4  out  WIDTH  id_pc + 4, modulo 2^WIDTH (return address)

Behaviour:
- Reset (rst=0 at an edge): count=0, read/write pointers=0, outstanding=0, discard=0.
  - Outputs after reset: imem_req=0, pc_en=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4.
- Reset mid-transaction: any in-flight response arriving after reset is ignored, because outstanding=0.
- Storage: occupancy = count + outstanding, never exceeds DEPTH.
- Request issue:
  - imem_req = rst & ~flush & (~outstanding | imem_rvalid) & (count + outstanding < DEPTH).
  - A same-cycle pop gives no credit: there is no combinational path from id_ready to imem_req.
  - imem_addr = fetch_pc, combinational.
  - Grant happens when imem_req & imem_gnt. That edge captures req_pc <= fetch_pc and sets outstanding=1.
  - At most one outstanding request.
- pc_en = (imem_req & imem_gnt) | flush.
  - On flush the PC loads the redirect target.
  - Otherwise the PC advances only on a granted fetch. The PC holds while stalled.
- Response:
  - imem_rvalid is accepted only while outstanding=1. It clears outstanding, unless a new grant happens in the same cycle.
  - If discard=0, {imem_rdata, req_pc} is written at wr_ptr; wr_ptr++ and count++.
  - If discard=1, the data is dropped and discard is cleared.
  - Minimum latency is 1 cycle after grant. Back-to-back is supported: rvalid and the next grant may coincide, giving 1 instruction per cycle.
- Dequeue:
  - id_valid = (count != 0). Pop happens when id_valid & id_ready; then rd_ptr++ and count--.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - While id_valid=0, id_instr and id_pc read 0.
- Flush (synchronous):
  - Next cycle: count=0, pointers=0, id_valid=0.
  - No request is issued in the flush cycle.
  - If outstanding=1 and imem_rvalid=0 in the flush cycle, set discard=1.
  - If imem_rvalid=1 in the flush cycle, the data is dropped and discard stays 0.
  - Flush overrides push and pop in the same cycle.
  - Flush while discard=1 keeps discard=1.
- Boundary cases:
  - Full: count=DEPTH, so imem_req=0.
  - Empty: id_valid=0, so id_ready is ignored.
  - imem_rvalid with outstanding=0 is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output id_misalign (1 bit). FIFO entries gain a misalign bit.
  - If fetch_pc[1:0] != 0 and the issue conditions hold, no memory request is made (imem_req=0).
  - Instead, an entry {32'h0000_0013 (NOP), fetch_pc, misalign=1} is pushed directly at the edge, counted as a grant for occupancy.
  - pc_en=0 for that cycle. Further fetch stops until flush. id_misalign reflects the head entry.
- When undefined: no port, no check. fetch_pc[1:0] passes through to imem_addr unchanged.

Test Plan:
- Reset: rst=0 for 2 cycles with imem_gnt=1 -> imem_req=0, pc_en=0, id_valid=0. After rst=1: imem_req=1, imem_addr=fetch_pc=0x0000_0000.
- Streaming: 1-cycle memory, gnt=1, id_ready=1, PC stepping 0x0,0x4,0x8 -> one instruction per cycle. id_pc sequence 0x0,0x4,0x8; id_pc_plus4 0x4,0x8,0xC; pc_en=1 each cycle.
- Backpressure: id_ready=0, DEPTH=4 -> exactly 4 grants. Then imem_req=0 and pc_en=0, PC held at 0x10. One pop -> a single new request is issued the following cycle.
- Flush during outstanding: grant at PC 0x20, flush next cycle with rvalid=0, rdata arriving 2 cycles later -> that data is dropped, FIFO empty. The next fetch uses the new fetch_pc 0x100 and id_pc=0x100.
- Wrap: WIDTH=32, head entry at 0xFFFF_FFFC -> id_pc_plus4=0x0000_0000. FIFO pointers wrap after 6 push/pop pairs with data order preserved.
- Misalign (with FETCH_MISALIGN_CHECK_EN): fetch_pc=0x0000_0102 -> no imem_req, id_valid=1 with id_instr=0x0000_0013, id_misalign=1, pc_en=0 until flush.
